// File: rtl/saida_display_if.sv
// Load-side bus between the control unit and the output display stage.
//   opr_in : load strobe from the control unit
//   bus    : 8-bit data bus (driven by the accumulator while acc_out is high)
// Modports: master drives the strobe and data, slave (the display stage) samples them.
interface saida_display_if;
  logic       opr_in;
  logic [7:0] bus;

  modport master (output opr_in, output bus);
  modport slave  (input  opr_in, input  bus);
endinterface

// File: rtl/saida_display.sv
// Output port stage with a 4-digit multiplexed 7-segment display.
// It latches the bus into the output register on opr_in. A sequential double-dabble
// converter then turns the latched value into BCD. A prescaled scanner cycles the
// four digits: units, tens, hundreds and sign.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous active-high reset
//   ctrl   : saida_display_if.slave (opr_in strobe, 8-bit bus)
//   saida  : output register value
//   busy   : conversion in progress (LOAD/SHIFT/DONE)
//   bcd    : registered {hundreds, tens, units}
//   seg    : segments, bit6..bit0 = g..a
//   an     : digit enables, an[0]=units .. an[3]=sign
//
// Optional feature: define SIGNED_DISPLAY_EN to treat saida as two's complement.
// The magnitude is then converted and a minus sign is shown on digit 3.
module saida_display #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  saida_display_if.slave        ctrl,
  output logic [7:0]            saida,
  output logic                  busy,
  output logic [11:0]           bcd,
  output logic [6:0]            seg,
  output logic [3:0]            an
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [7:0]      saida_q;
  logic [1:0]      state_q, state_d;
  logic [19:0]     sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [1:0]      dig_q, dig_d;
  logic [7:0]      mag;
  logic            sign_show;
  logic [19:0]     sr_adj;

  // Output register
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_q <= 8'h00;
    end else if (ctrl.opr_in) begin
      saida_q <= ctrl.bus;
    end
  end

`ifdef SIGNED_DISPLAY_EN
  logic sign_q, sign_d;
  logic sign_disp_q, sign_disp_d;

  // Two's-complement magnitude; 8'h80 negates to itself, which reads as 128 unsigned.
  assign mag       = saida_q[7] ? (~saida_q + 8'd1) : saida_q;
  assign sign_show = sign_disp_q;

  always_comb begin
    sign_d      = sign_q;
    sign_disp_d = sign_disp_q;
    if (state_q == StLoad) sign_d = saida_q[7];
    if (state_q == StDone) sign_disp_d = sign_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sign_q      <= 1'b0;
      sign_disp_q <= 1'b0;
    end else begin
      sign_q      <= sign_d;
      sign_disp_q <= sign_disp_d;
    end
  end
`else
  assign mag       = saida_q;
  assign sign_show = 1'b0;
`endif

  // Double-dabble add-3 on each BCD nibble before the shift
  always_comb begin
    sr_adj = sr_q;
    if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
    if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
    if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      StIdle: ;
      StLoad: begin
        sr_d    = {12'b0, mag};
        cnt_d   = 3'd0;
        state_d = StShift;
      end
      StShift: begin
        sr_d  = {sr_adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        bcd_d   = sr_q[19:8];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new strobe always restarts; an aborted run never reaches DONE.
    if (ctrl.opr_in) state_d = StLoad;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= 20'h0;
      cnt_q   <= 3'd0;
      bcd_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Digit scanner
  always_comb begin
    pre_d = pre_q + PreW'(1);
    dig_d = dig_q;
    if (pre_q == PreMax) begin
      pre_d = '0;
      dig_d = dig_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
      dig_q <= 2'd0;
    end else begin
      pre_q <= pre_d;
      dig_q <= dig_d;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  logic [6:0] seg_act;
  logic [3:0] an_act;

  // Decoded from registered bcd only, so conversion progress is never visible
  always_comb begin
    seg_act = 7'h00;
    case (dig_q)
      2'd0: seg_act = glyph(bcd_q[3:0]);
      2'd1: seg_act = (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) ? 7'h00 : glyph(bcd_q[7:4]);
      2'd2: seg_act = (bcd_q[11:8] == 4'd0) ? 7'h00 : glyph(bcd_q[11:8]);
      2'd3: seg_act = sign_show ? 7'h40 : 7'h00;
      default: seg_act = 7'h00;
    endcase
    an_act = 4'b0001 << dig_q;
  end

  assign saida = saida_q;
  assign busy  = (state_q != StIdle);
  assign bcd   = bcd_q;
  assign seg   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
  assign an    = AN_ACTIVE_LOW ? ~an_act : an_act;

endmodule

// File: tb/tb_saida_display.sv
module tb_saida_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  saida;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  saida_display_if bus_if ();

  saida_display #(
    .REFRESH_DIV   (4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clock(clk),
    .reset(rst),
    .ctrl (bus_if),
    .saida(saida),
    .busy (busy),
    .bcd  (bcd),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_cap [4];
  logic [3:0] an_cap  [4];
  int         hold_bad;
  bit         align_ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.opr_in = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] v);
    bus_if.opr_in = 1'b1;
    bus_if.bus    = v;
    step();
    bus_if.opr_in = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Aligns to the first cycle of digit 0, then records one full scan (no comparisons).
  task automatic capture_scan();
    int i;
    align_ok = 1'b0;
    hold_bad = 0;
    i = 0;
    while (an !== 4'b0111 && i < 20) begin step(); i++; end
    i = 0;
    while (an !== 4'b1110 && i < 8) begin step(); i++; end
    if (an === 4'b1110) align_ok = 1'b1;
    for (int d = 0; d < 4; d++) begin
      an_cap[d]  = an;
      seg_cap[d] = seg;
      for (int c = 0; c < 4; c++) begin
        if (an !== an_cap[d] || seg !== seg_cap[d]) hold_bad++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (saida !== 8'h00) begin n_errors++; $display("FAIL reset_saida got %h exp 00", saida); end
    n_checks++; if (bcd !== 12'h000) begin n_errors++; $display("FAIL reset_bcd got %h exp 000", bcd); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (an !== 4'b1110) begin n_errors++; $display("FAIL reset_an got %b exp 1110", an); end
    n_checks++; if (seg !== 7'h40) begin n_errors++; $display("FAIL reset_seg got %h exp 40", seg); end
  endtask

  task automatic test_ff();
    int cnt;
    logic [11:0] e_bcd;
    logic [6:0]  e_seg [4];
`ifdef SIGNED_DISPLAY_EN
    e_bcd = 12'h001;
    e_seg[0] = 7'h79; e_seg[1] = 7'h7F; e_seg[2] = 7'h7F; e_seg[3] = 7'h3F;
`else
    e_bcd = 12'h255;
    e_seg[0] = 7'h12; e_seg[1] = 7'h12; e_seg[2] = 7'h24; e_seg[3] = 7'h7F;
`endif
    do_reset();
    strobe(8'hFF);
    n_checks++; if (saida !== 8'hFF) begin n_errors++; $display("FAIL ff_saida got %h exp FF", saida); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin cnt++; step(); end
    n_checks++; if (cnt != 10) begin n_errors++; $display("FAIL ff_busy_len got %0d exp 10", cnt); end
    n_checks++; if (bcd !== e_bcd) begin n_errors++; $display("FAIL ff_bcd got %h exp %h", bcd, e_bcd); end
    capture_scan();
    n_checks++; if (!align_ok) begin n_errors++; $display("FAIL ff_scan_align got 0 exp 1"); end
    n_checks++; if (hold_bad != 0) begin n_errors++; $display("FAIL ff_scan_hold got %0d exp 0", hold_bad); end
    n_checks++; if (an !== 4'b1110) begin n_errors++; $display("FAIL ff_scan_wrap got %b exp 1110", an); end
    for (int d = 0; d < 4; d++) begin
      logic [3:0] e_an;
      e_an = ~(4'b0001 << d);
      n_checks++;
      if (an_cap[d] !== e_an) begin
        n_errors++; $display("FAIL ff_an[%0d] got %b exp %b", d, an_cap[d], e_an);
      end
      n_checks++;
      if (seg_cap[d] !== e_seg[d]) begin
        n_errors++; $display("FAIL ff_seg[%0d] got %h exp %h", d, seg_cap[d], e_seg[d]);
      end
    end
  endtask

  task automatic test_seven();
    bit ok;
    strobe(8'h07);
    wait_idle(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL seven_timeout got busy exp idle"); end
    n_checks++; if (bcd !== 12'h007) begin n_errors++; $display("FAIL seven_bcd got %h exp 007", bcd); end
    capture_scan();
    n_checks++; if (seg_cap[0] !== 7'h78) begin n_errors++; $display("FAIL seven_units got %h exp 78", seg_cap[0]); end
    n_checks++; if (seg_cap[1] !== 7'h7F) begin n_errors++; $display("FAIL seven_tens got %h exp 7F", seg_cap[1]); end
    n_checks++; if (seg_cap[2] !== 7'h7F) begin n_errors++; $display("FAIL seven_hund got %h exp 7F", seg_cap[2]); end
  endtask

  task automatic test_abort();
    int drop = 0;
    int seen = 0;
    do_reset();
    strobe(8'h0A);
    if (busy !== 1'b1) drop++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy !== 1'b1) drop++;
      if (bcd === 12'h010) seen++;
    end
    strobe(8'h64);
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b1) drop++;
      if (bcd === 12'h010) seen++;
      step();
    end
    n_checks++; if (drop != 0) begin n_errors++; $display("FAIL abort_busy_gap got %0d exp 0", drop); end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL abort_bcd_010 got %0d exp 0", seen); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_done_busy got %b exp 0", busy); end
    n_checks++; if (bcd !== 12'h100) begin n_errors++; $display("FAIL abort_bcd got %h exp 100", bcd); end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    strobe(8'hC8);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (saida !== 8'h00) begin n_errors++; $display("FAIL midrst_saida got %h exp 00", saida); end
    n_checks++; if (bcd !== 12'h000) begin n_errors++; $display("FAIL midrst_bcd got %h exp 000", bcd); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_checks++; if (an !== 4'b1110) begin n_errors++; $display("FAIL midrst_an got %b exp 1110", an); end
    n_checks++; if (seg !== 7'h40) begin n_errors++; $display("FAIL midrst_seg got %h exp 40", seg); end
    for (int i = 0; i < 15; i++) step();
    n_checks++; if (bcd !== 12'h000) begin n_errors++; $display("FAIL midrst_late_bcd got %h exp 000", bcd); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL midrst_late_busy got 1 exp 0"); end
  endtask

  task automatic test_hold();
    bit ok;
    strobe(8'h2A);
    wait_idle(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL hold_timeout got busy exp idle"); end
    for (int i = 0; i < 20; i++) begin
      bus_if.bus = (i % 2 == 0) ? 8'h00 : 8'hFF;
      step();
      n_checks++;
      if (saida !== 8'h2A) begin n_errors++; $display("FAIL hold_saida got %h exp 2A", saida); end
      n_checks++;
      if (bcd !== 12'h042) begin n_errors++; $display("FAIL hold_bcd got %h exp 042", bcd); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL hold_busy got %b exp 0", busy); end
    end
  endtask

  task automatic test_sign();
    bit ok;
    strobe(8'h80);
    wait_idle(ok);
    n_checks++; if (bcd !== 12'h128) begin n_errors++; $display("FAIL sign80_bcd got %h exp 128", bcd); end
    capture_scan();
    n_checks++; if (seg_cap[0] !== 7'h00) begin n_errors++; $display("FAIL sign80_units got %h exp 00", seg_cap[0]); end
    n_checks++; if (seg_cap[1] !== 7'h24) begin n_errors++; $display("FAIL sign80_tens got %h exp 24", seg_cap[1]); end
    n_checks++; if (seg_cap[2] !== 7'h79) begin n_errors++; $display("FAIL sign80_hund got %h exp 79", seg_cap[2]); end
`ifdef SIGNED_DISPLAY_EN
    n_checks++; if (seg_cap[3] !== 7'h3F) begin n_errors++; $display("FAIL sign80_minus got %h exp 3F", seg_cap[3]); end
    strobe(8'hFF);
    wait_idle(ok);
    n_checks++; if (bcd !== 12'h001) begin n_errors++; $display("FAIL signff_bcd got %h exp 001", bcd); end
    capture_scan();
    n_checks++; if (seg_cap[3] !== 7'h3F) begin n_errors++; $display("FAIL signff_minus got %h exp 3F", seg_cap[3]); end
`else
    n_checks++; if (seg_cap[3] !== 7'h7F) begin n_errors++; $display("FAIL sign80_blank got %h exp 7F", seg_cap[3]); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus_if.opr_in = 1'b0;
    bus_if.bus = 8'h00;
    test_reset();
    test_ff();
    test_seven();
    test_abort();
    test_reset_mid_shift();
    test_hold();
    test_sign();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/saida_display.md
Name: saida_display

Overview:
- Output port stage downstream of the control unit: consumes `opr_in` and the 8-bit bus (driven by the accumulator while `acc_out` is asserted).
- Latches the bus into the output register.
- Converts the latched value to BCD with a sequential double-dabble FSM.
- Drives a 4-digit multiplexed 7-segment display.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit; minimum legal value 2.
- SEG_ACTIVE_LOW, 1: 1 = `seg` bits are driven low to light a segment.
- AN_ACTIVE_LOW, 1: 1 = the selected `an` bit is driven low.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opr_in  input  1  load strobe from the control unit.
- bus  input  8  data bus; sampled when `opr_in`=1.
- saida  output  8  output register value.
- busy  output  1  high while a conversion is in progress.
- bcd  output  12  converted digits {hundreds, tens, units}, registered.
- seg  output  7  segments; bit6..bit0 = g..a.
- an  output  4  digit enables; an[0]=units, an[1]=tens, an[2]=hundreds, an[3]=sign.

Behaviour:
- Reset (`reset`=1 at an edge) overrides everything:
  - `saida`=0, `bcd`=0, FSM=IDLE, `busy`=0, prescaler=0, digit index=0.
  - Outputs therefore show "0" on units, all other digits blank.
- Output register: edge with `opr_in`=1 loads `saida` <= `bus`, visible the next cycle. With `opr_in`=0, `saida` holds regardless of `bus`.
- Converter FSM has states IDLE, LOAD, SHIFT, DONE.
  - `opr_in` at edge E0 forces state LOAD from ANY state. A strobe during a conversion aborts it and restarts with the new value.
  - LOAD at E1: shift register <= {12'b0, `saida`}; count <= 0; go to SHIFT.
  - SHIFT, E2..E9, 8 iterations: each BCD nibble >=5 gets +3, then the 20-bit register shifts left by 1. After the 8th iteration go to DONE.
  - DONE at E10: `bcd` <= upper 12 bits; go to IDLE.
  - `busy`=1 in LOAD, SHIFT and DONE, i.e. for exactly 10 cycles after E0 with no further strobe.
  - `bcd` keeps its previous value until DONE; an aborted conversion never updates `bcd`.
  - Maximum value 255 gives `bcd`=12'h255. No overflow is possible.
- Scanner:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments mod 4 (3 -> 0).
  - Exactly one `an` bit is active at a time; it is the bit for the digit index.
- Glyphs, active-high form (inverted when SEG_ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - minus=40, blank=00.
- Leading-zero blanking:
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when hundreds=0 and tens=0.
  - Units digit is always shown.
  - Sign digit is blank unless the optional feature selects minus.
- The display always reflects registered `bcd`; it never shows intermediate conversion state.
- `seg`/`an` are decoded from registered state only, with no dependence on `bus`.

Optional Feature:
- Macro: SIGNED_DISPLAY_EN.
- Defined:
  - `saida` is treated as two's complement.
  - LOAD converts the magnitude; -128 converts to 128.
  - A sign flag is captured in LOAD and transferred to the display in DONE together with `bcd`.
  - Digit 3 shows minus when the sign flag is negative, blank otherwise.
- Undefined: value is unsigned 0..255, digit 3 is always blank, and no sign flag exists.

Test Plan (all scenarios use REFRESH_DIV=4, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1):
- Reset, then `opr_in`=1 with `bus`=FF for 1 cycle:
  - `saida`=FF next cycle; `busy` high for exactly 10 cycles; then `bcd`=255.
  - Scan gives an=1110/seg=~6D, an=1101/seg=~6D, an=1011/seg=~5B, an=0111/seg=7F (blank), each held for 4 cycles.
- `bus`=07 strobe -> `bcd`=007; hundreds and tens digits blank (seg=7F); units digit seg=~07.
- Strobe `bus`=0A, then strobe `bus`=64 on the 4th busy cycle:
  - `bcd` never equals 010.
  - `bcd`=100 ten cycles after the second strobe; `busy` stays continuously high throughout.
- `reset` asserted mid-SHIFT -> next cycle `saida`=0, `bcd`=0, `busy`=0, an=1110, seg=~3F. No later `bcd` update occurs.
- `opr_in`=0 while `bus` toggles 00/FF for 20 cycles -> `saida`, `bcd` and `busy` are unchanged.
- With SIGNED_DISPLAY_EN:
  - `bus`=80 -> `bcd`=128, digit 3 shows minus.
  - `bus`=FF -> `bcd`=001, minus shown.
- Without SIGNED_DISPLAY_EN: `bus`=80 -> `bcd`=128, digit 3 blank.
